// File: rtl/mips_ctrl_pkg.sv
// Shared definitions for the multi-cycle MIPS control unit: ULA operation
// encoding, instruction field constants, FSM state encoding, datapath mux
// selects and the per-state control word decode.
package mips_ctrl_pkg;

  localparam int ULA_OP_W = 5;

  // Operation encoding shared with the ULA
  typedef enum logic [ULA_OP_W-1:0] {
    ULA_AND    = 5'd0,
    ULA_OR     = 5'd1,
    ULA_ADD    = 5'd2,
    ULA_PASS_A = 5'd3,
    ULA_EQ     = 5'd4,
    ULA_NE     = 5'd5,
    ULA_SUB    = 5'd6,
    ULA_SLT    = 5'd7,
    ULA_LUI    = 5'd8,
    ULA_SLL    = 5'd9,
    ULA_SRL    = 5'd10,
    ULA_NOR    = 5'd11
  } ula_op_t;

  // Opcodes (IR[31:26])
  localparam logic [5:0] OPC_RTYPE = 6'h00;
  localparam logic [5:0] OPC_J     = 6'h02;
  localparam logic [5:0] OPC_JAL   = 6'h03;
  localparam logic [5:0] OPC_BEQ   = 6'h04;
  localparam logic [5:0] OPC_BNE   = 6'h05;
  localparam logic [5:0] OPC_ADDI  = 6'h08;
  localparam logic [5:0] OPC_SLTI  = 6'h0A;
  localparam logic [5:0] OPC_ANDI  = 6'h0C;
  localparam logic [5:0] OPC_ORI   = 6'h0D;
  localparam logic [5:0] OPC_LUI   = 6'h0F;
  localparam logic [5:0] OPC_LW    = 6'h23;
  localparam logic [5:0] OPC_SW    = 6'h2B;

  // R-type function codes (IR[5:0])
  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;

  // Datapath mux selects
  localparam logic [1:0] SRC_B_REG    = 2'b00;
  localparam logic [1:0] SRC_B_FOUR   = 2'b01;
  localparam logic [1:0] SRC_B_IMM    = 2'b10;
  localparam logic [1:0] SRC_B_IMM_SH = 2'b11;

  localparam logic [1:0] PC_SRC_ULA    = 2'b00;
  localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_SRC_JUMP   = 2'b10;
  localparam logic [1:0] PC_SRC_REG    = 2'b11;

  localparam logic [1:0] REG_DST_RT = 2'b00;
  localparam logic [1:0] REG_DST_RD = 2'b01;
  localparam logic [1:0] REG_DST_RA = 2'b10;

  localparam logic [1:0] MEM_TO_REG_ALUOUT = 2'b00;
  localparam logic [1:0] MEM_TO_REG_MDR    = 2'b01;
  localparam logic [1:0] MEM_TO_REG_PC     = 2'b10;

  typedef enum logic [3:0] {
    ST_FETCH, ST_DECODE, ST_MEM_ADDR, ST_MEM_READ, ST_MEM_WB, ST_MEM_WRITE,
    ST_EXEC_R, ST_R_WB, ST_EXEC_I, ST_I_WB, ST_BRANCH, ST_JUMP, ST_JR,
    ST_JAL, ST_TRAP
  } state_t;

  // Control word that depends only on the FSM state. 'fetch' marks the state
  // whose ir_write/pc_write are qualified by mem_ready.
  typedef struct packed {
    logic       fetch;
    logic       mem_read;
    logic       mem_write;
    logic       i_or_d;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       pc_write;
    logic       pc_write_cond;
    logic [1:0] pc_source;
    logic       reg_write;
    logic [1:0] reg_dst;
    logic [1:0] mem_to_reg;
  } ctrl_t;

  function automatic ctrl_t state_ctrl(input state_t s);
    ctrl_t c;
    c = '0;
    case (s)
      ST_FETCH: begin
        c.fetch     = 1'b1;
        c.mem_read  = 1'b1;
        c.alu_src_b = SRC_B_FOUR;
        c.pc_source = PC_SRC_ULA;
      end
      ST_DECODE:    c.alu_src_b = SRC_B_IMM_SH;
      ST_MEM_ADDR: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRC_B_IMM;
      end
      ST_MEM_READ: begin
        c.mem_read = 1'b1;
        c.i_or_d   = 1'b1;
      end
      ST_MEM_WB: begin
        c.reg_write  = 1'b1;
        c.reg_dst    = REG_DST_RT;
        c.mem_to_reg = MEM_TO_REG_MDR;
      end
      ST_MEM_WRITE: begin
        c.mem_write = 1'b1;
        c.i_or_d    = 1'b1;
      end
      ST_EXEC_R: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRC_B_REG;
      end
      ST_R_WB: begin
        c.reg_write  = 1'b1;
        c.reg_dst    = REG_DST_RD;
        c.mem_to_reg = MEM_TO_REG_ALUOUT;
      end
      ST_EXEC_I: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRC_B_IMM;
      end
      ST_I_WB: begin
        c.reg_write  = 1'b1;
        c.reg_dst    = REG_DST_RT;
        c.mem_to_reg = MEM_TO_REG_ALUOUT;
      end
      ST_BRANCH: begin
        c.alu_src_a     = 1'b1;
        c.alu_src_b     = SRC_B_REG;
        c.pc_write_cond = 1'b1;
        c.pc_source     = PC_SRC_ALUOUT;
      end
      ST_JUMP: begin
        c.pc_write  = 1'b1;
        c.pc_source = PC_SRC_JUMP;
      end
      ST_JR: begin
        c.pc_write  = 1'b1;
        c.pc_source = PC_SRC_REG;
      end
      ST_JAL: begin
        c.pc_write   = 1'b1;
        c.pc_source  = PC_SRC_JUMP;
        c.reg_write  = 1'b1;
        c.reg_dst    = REG_DST_RA;
        c.mem_to_reg = MEM_TO_REG_PC;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/mips_ula_dec.sv
// ULA operation lookup: funct for R-type, opcode for immediate ALU
// instructions. 'valid' is low for encodings the ULA cannot execute.
module mips_ula_dec
  import mips_ctrl_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output ula_op_t    ula_op,
  output logic       valid
);

  // Table lookup shared by the R-type and I-type execute states
  always_comb begin
    ula_op = ULA_ADD;
    valid  = 1'b1;
    if (opcode == OPC_RTYPE) begin
      case (funct)
        FN_ADD, FN_ADDU: ula_op = ULA_ADD;
        FN_SUB, FN_SUBU: ula_op = ULA_SUB;
        FN_AND:          ula_op = ULA_AND;
        FN_OR:           ula_op = ULA_OR;
        FN_NOR:          ula_op = ULA_NOR;
        FN_SLT:          ula_op = ULA_SLT;
        FN_SLL:          ula_op = ULA_SLL;
        FN_SRL:          ula_op = ULA_SRL;
        default:         valid  = 1'b0;
      endcase
    end else begin
      case (opcode)
        OPC_ADDI: ula_op = ULA_ADD;
        OPC_SLTI: ula_op = ULA_SLT;
        OPC_ANDI: ula_op = ULA_AND;
        OPC_ORI:  ula_op = ULA_OR;
        OPC_LUI:  ula_op = ULA_LUI;
        default:  valid  = 1'b0;
      endcase
    end
  end

endmodule

// File: rtl/mips_ctrl_multiciclo.sv
// Multi-cycle MIPS control unit. Moore FSM whose control word is registered
// alongside the state; only the fetch enables (mem_ready) and the branch
// PC enable (zero) are combined combinationally. All outputs are forced low
// while reset is high.
// Optional macro MIPS_CTRL_TRAP_EN: undefined instructions lock the FSM in a
// TRAP state with illegal=1; otherwise they retire as NOPs.
module mips_ctrl_multiciclo
  import mips_ctrl_pkg::*;
#(
  parameter int OP_W  = ULA_OP_W,
  parameter int CNT_W = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic             zero,
  input  logic             mem_ready,
  output logic [OP_W-1:0]  ula_op,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic             i_or_d,
  output logic             mem_read,
  output logic             mem_write,
  output logic             ir_write,
  output logic             pc_write,
  output logic             pc_write_cond,
  output logic [1:0]       pc_source,
  output logic             reg_write,
  output logic [1:0]       reg_dst,
  output logic [1:0]       mem_to_reg,
  output logic [CNT_W-1:0] instr_count,
  output logic             illegal
);

`ifdef MIPS_CTRL_TRAP_EN
  localparam state_t ILLEGAL_NEXT = ST_TRAP;
`else
  localparam state_t ILLEGAL_NEXT = ST_FETCH;
`endif

  state_t           state_reg, state_next;
  ctrl_t            ctrl_reg;
  ula_op_t          ula_op_reg, ula_op_next;
  logic [CNT_W-1:0] count_reg;
  ula_op_t          dec_op;
  logic             dec_valid;
  logic             retire;
  logic             run;
  logic             branch_taken;

  mips_ula_dec u_ula_dec (
    .opcode (opcode),
    .funct  (funct),
    .ula_op (dec_op),
    .valid  (dec_valid)
  );

  // Next-state selection; mem_ready only matters in the memory-wait states
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_FETCH: if (mem_ready) state_next = ST_DECODE;
      ST_DECODE: begin
        case (opcode)
          OPC_LW, OPC_SW: state_next = ST_MEM_ADDR;
          OPC_RTYPE: begin
            if (funct == FN_JR)  state_next = ST_JR;
            else if (dec_valid)  state_next = ST_EXEC_R;
            else                 state_next = ILLEGAL_NEXT;
          end
          OPC_BEQ, OPC_BNE: state_next = ST_BRANCH;
          OPC_J:            state_next = ST_JUMP;
          OPC_JAL:          state_next = ST_JAL;
          OPC_ADDI, OPC_SLTI, OPC_ANDI, OPC_ORI, OPC_LUI:
                            state_next = ST_EXEC_I;
          default:          state_next = ILLEGAL_NEXT;
        endcase
      end
      ST_MEM_ADDR:  state_next = (opcode == OPC_LW) ? ST_MEM_READ : ST_MEM_WRITE;
      ST_MEM_READ:  if (mem_ready) state_next = ST_MEM_WB;
      ST_MEM_WRITE: if (mem_ready) state_next = ST_FETCH;
      ST_EXEC_R:    state_next = ST_R_WB;
      ST_EXEC_I:    state_next = ST_I_WB;
      ST_TRAP:      state_next = ST_TRAP;
      default:      state_next = ST_FETCH;
    endcase
  end

  // ULA operation to present in the upcoming state
  always_comb begin
    case (state_next)
      ST_EXEC_R, ST_EXEC_I: ula_op_next = dec_op;
      ST_BRANCH:            ula_op_next = ULA_SUB;
      default:              ula_op_next = ULA_ADD;
    endcase
  end

  assign retire = (state_reg != ST_FETCH) && (state_next == ST_FETCH);

  // State, registered control word and retired-instruction counter
  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg  <= ST_FETCH;
      ctrl_reg   <= state_ctrl(ST_FETCH);
      ula_op_reg <= ULA_ADD;
      count_reg  <= '0;
    end else begin
      state_reg  <= state_next;
      ctrl_reg   <= state_ctrl(state_next);
      ula_op_reg <= ula_op_next;
      if (retire) count_reg <= count_reg + CNT_W'(1);
    end
  end

`ifdef MIPS_CTRL_TRAP_EN
  logic illegal_reg;

  // Trap indicator follows the state into TRAP and stays until reset
  always_ff @(posedge clock) begin
    if (reset) illegal_reg <= 1'b0;
    else       illegal_reg <= (state_next == ST_TRAP);
  end

  assign illegal = ~reset & illegal_reg;
`else
  assign illegal = 1'b0;
`endif

  assign run          = ~reset;
  assign branch_taken = ctrl_reg.pc_write_cond &
                        (((opcode == OPC_BEQ) & zero) | ((opcode == OPC_BNE) & ~zero));

  assign ula_op        = run ? OP_W'(ula_op_reg) : '0;
  assign alu_src_a     = run & ctrl_reg.alu_src_a;
  assign alu_src_b     = run ? ctrl_reg.alu_src_b : 2'b00;
  assign i_or_d        = run & ctrl_reg.i_or_d;
  assign mem_read      = run & ctrl_reg.mem_read;
  assign mem_write     = run & ctrl_reg.mem_write;
  assign ir_write      = run & ctrl_reg.fetch & mem_ready;
  assign pc_write      = run & (ctrl_reg.pc_write | (ctrl_reg.fetch & mem_ready) | branch_taken);
  assign pc_write_cond = run & ctrl_reg.pc_write_cond;
  assign pc_source     = run ? ctrl_reg.pc_source : 2'b00;
  assign reg_write     = run & ctrl_reg.reg_write;
  assign reg_dst       = run ? ctrl_reg.reg_dst : 2'b00;
  assign mem_to_reg    = run ? ctrl_reg.mem_to_reg : 2'b00;
  assign instr_count   = run ? count_reg : '0;

endmodule

// File: doc/mips_ctrl_multiciclo.md
Name: mips_ctrl_multiciclo

Overview:
- Multi-cycle MIPS control unit: the initiator that drives the 32-bit ULA through its OP/SHAMT selection interface.
- Sequences each instruction through fetch, decode, execute, memory and writeback states.
- Emits ULA op codes and datapath enables; consumes the ULA zero flag for branches.
- Sits between instruction register, memory handshake and datapath muxes.

Parameters:
- OP_W, 5, width of ULA operation code
- CNT_W, 32, width of retired-instruction counter

Ports:
- clock  in  1  single system clock, rising edge
- reset  in  1  synchronous, active-high
- opcode  in  6  IR[31:26]
- funct  in  6  IR[5:0]
- zero  in  1  ULA Z flag, combinational from the current op
- mem_ready  in  1  memory completes the current read/write this cycle
- ula_op  out  OP_W  operation select to ULA
- alu_src_a  out  1  0=PC, 1=reg A
- alu_src_b  out  2  00=reg B, 01=const 4, 10=sign-ext imm, 11=sign-ext imm<<2
- i_or_d  out  1  0=PC address, 1=ALUOut address
- mem_read, mem_write  out  1  memory request, held until mem_ready
- ir_write, pc_write, pc_write_cond  out  1  register enables
- pc_source  out  2  00=ULA result, 01=ALUOut, 10=jump target, 11=reg A (jr)
- reg_write  out  1  register file write enable
- reg_dst  out  2  00=rt, 01=rd, 10=$31
- mem_to_reg  out  2  00=ALUOut, 01=MDR, 10=PC (jal)
- instr_count  out  CNT_W  retired instructions, wraps at 2^CNT_W
- illegal  out  1  see Optional Feature

Behaviour:
- Interface encoding, shared with ULA: AND=0, OR=1, ADD=2, PASS_A=3, EQ=4, NE=5, SUB=6, SLT=7, LUI=8, SLL=9, SRL=10, NOR=11.
- Moore FSM. Outputs decode only from state, except FETCH/MEM enables, which are qualified by mem_ready.
- While reset=1: state<=FETCH, instr_count<=0, all outputs 0. Reset mid-instruction aborts it with no writes.
- FETCH:
  - Drives mem_read=1, i_or_d=0, ula_op=ADD, src_a=0, src_b=01, pc_source=00.
  - Stays while mem_ready=0.
  - On mem_ready=1: ir_write=1 and pc_write=1 in that same cycle, then go to DECODE.
- DECODE: ula_op=ADD, src_a=0, src_b=11 (branch target into ALUOut). Next state by opcode:
  - 0x23/0x2B → MEM_ADDR
  - 0x00 → EXEC_R, except funct 0x08 → JR
  - 0x04/0x05 → BRANCH
  - 0x02 → JUMP
  - 0x03 → JAL
  - 0x08/0x0A/0x0C/0x0D/0x0F → EXEC_I
  - other → ILLEGAL handling
- MEM_ADDR: ula_op=ADD, src_a=1, src_b=10. Next: lw → MEM_READ, sw → MEM_WRITE.
- MEM_READ: mem_read=1, i_or_d=1; wait for mem_ready; then MEM_WB.
- MEM_WB: reg_write=1, reg_dst=00, mem_to_reg=01; then FETCH.
- MEM_WRITE: mem_write=1, i_or_d=1; wait for mem_ready; then FETCH.
- EXEC_R: src_a=1, src_b=00. ula_op by funct:
  - 0x20/0x21 → ADD
  - 0x22/0x23 → SUB
  - 0x24 → AND
  - 0x25 → OR
  - 0x27 → NOR
  - 0x2A → SLT
  - 0x00 → SLL
  - 0x02 → SRL
  - other funct → ILLEGAL
  - Then R_WB: reg_write=1, reg_dst=01, mem_to_reg=00.
- EXEC_I: src_a=1, src_b=10. ula_op by opcode: addi → ADD, slti → SLT, andi → AND, ori → OR, lui → LUI. Then I_WB: reg_write, reg_dst=00.
- BRANCH: ula_op=SUB, src_a=1, src_b=00, pc_source=01. pc_write=1 iff (beq & zero) | (bne & ~zero), evaluated in this cycle.
- JUMP: pc_write=1, pc_source=10.
- JR: pc_write=1, pc_source=11.
- JAL: reg_write=1, reg_dst=10, mem_to_reg=10, pc_write=1, pc_source=10.
- instr_count increments on every transition into FETCH from a non-FETCH state; wraps to 0 at 2^CNT_W.
- Latency:
  - lw: 5 cycles plus memory waits.
  - sw, R-type, I-type: 4 cycles.
  - branch, j, jr, jal: 3 cycles.
- mem_ready arriving outside FETCH/MEM_READ/MEM_WRITE is ignored.

Optional Feature:
- Macro: MIPS_CTRL_TRAP_EN.
- Defined: undefined opcode/funct enters TRAP state. TRAP asserts illegal=1 and no write enables, and holds until reset. instr_count is not incremented.
- Undefined: undefined opcode/funct goes FETCH directly, i.e. a NOP. It is counted as retired, and illegal is tied to 0.

Decomposition:
- Package mips_ctrl_pkg holds:
  - ULA op code localparams, OP_W, opcode and funct constants
  - state encoding enum
  - mux select constants for alu_src_b, pc_source, reg_dst, mem_to_reg
- One sub-module mips_ula_dec: combinational funct/opcode → ula_op lookup, reused by EXEC_R and EXEC_I.

Test Plan:
- Reset held 3 cycles mid-MEM_READ → all outputs 0, instr_count=0; first post-reset cycle is FETCH with mem_read=1.
- add (op 0x00, funct 0x20), mem_ready=1 in FETCH:
  - ula_op=2 in EXEC_R
  - reg_write=1, reg_dst=01 in R_WB
  - instr_count 0→1 after 4 cycles
- lw with mem_ready low 3 cycles in MEM_READ → mem_read and i_or_d=1 held 4 cycles; MEM_WB follows; total 8 cycles.
- Branches in BRANCH state:
  - beq with zero=1 → pc_write=1, pc_source=01, ula_op=6
  - beq with zero=0 → pc_write=0
  - bne with zero=0 → pc_write=1
- jal → reg_dst=10, mem_to_reg=10, pc_source=10, reg_write=1, pc_write=1 in one cycle.
- Opcode 0x3F:
  - with MIPS_CTRL_TRAP_EN: illegal=1 persists, instr_count frozen
  - without: returns to FETCH after DECODE, instr_count+1
